// File: rtl/gray_pkg.sv
// gray_pkg: mode codes, slicing math and reference Gray/binary conversions
package gray_pkg;
  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic logic [63:0] gray2bin(input logic [63:0] g, input int width);
    logic [63:0] b;
    b = '0;
    b[width-1] = g[width-1];
    for (int i = width - 2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
    return b;
  endfunction

  function automatic logic [63:0] bin2gray(input logic [63:0] b, input int width);
    logic [63:0] m;
    m = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (b & m) ^ ((b & m) >> 1);
  endfunction
endpackage

// File: rtl/gray_pipe_stage.sv
// gray_pipe_stage: one valid/ready register slice resolving Gray->binary bits [HI:LO]
module gray_pipe_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HI    = 7,
  parameter int LO    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);
  logic             valid_q, valid_d, mode_q, mode_d, load, acc;
  logic [WIDTH-1:0] data_q, data_d, conv;
  always_comb begin
    conv = in_data;
    acc  = 1'b0;
    // acc walks down the word so the bit just above HI acts as the prefix carry
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i <= HI && i >= LO && in_mode == MODE_G2B) conv[i] = in_data[i] ^ acc;
      acc = conv[i];
    end
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = load || (valid_q && !out_ready);
    mode_d   = load ? in_mode : mode_q;
    data_d   = load ? conv : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_mode  = mode_q;
  assign out_data  = data_q;
endmodule

// File: rtl/gray_bin_pipe.sv
// gray_bin_pipe: pipelined Gray<->binary converter with valid/ready streaming
module gray_bin_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);
  localparam int SLICE = slice_width(WIDTH, STAGES);
  logic [STAGES:0]  v, r, m;
  logic [WIDTH-1:0] d [STAGES+1];
  // binary->Gray is a single XOR layer, done before the first register
  assign v[0]      = in_valid;
  assign m[0]      = in_mode;
  assign d[0]      = (in_mode == MODE_B2G) ? (in_data ^ (in_data >> 1)) : in_data;
  assign in_ready  = r[0];
  assign r[STAGES] = out_ready;
  assign out_valid = v[STAGES];
  assign out_mode  = m[STAGES];
  assign out_data  = d[STAGES];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI_K = WIDTH - 1 - k * SLICE;
    localparam int LO_R = WIDTH - (k + 1) * SLICE;
    localparam int LO_K = (LO_R < 0) ? 0 : LO_R;
    gray_pipe_stage #(.WIDTH(WIDTH), .HI(HI_K), .LO(LO_K)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v[k]),
      .in_ready  (r[k]),
      .in_mode   (m[k]),
      .in_data   (d[k]),
      .out_valid (v[k+1]),
      .out_ready (r[k+1]),
      .out_mode  (m[k+1]),
      .out_data  (d[k+1])
    );
  end
endmodule

// File: doc/gray_bin_pipe.md
# gray_bin_pipe

Parametrised, pipelined Gray/binary code converter with valid/ready streaming handshake. It generalises the team's fixed 4-bit combinational Gray-to-binary decoder to any width. It adds a per-beat direction select (Gray→binary or binary→Gray) and splits the serial XOR prefix chain across a configurable number of register stages to meet timing at wide widths. It sits between counter/CDC pointer logic and downstream consumers that need either code.

## Interface
- `WIDTH`, default 8: data width in bits; legal range 2..64.
- `STAGES`, default 2: register stages; legal range 1..WIDTH; this is also the latency in cycles.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_mode` in 1: 0 = Gray→binary, 1 = binary→Gray; sampled with the beat.
- `in_data` in WIDTH: value to convert.
- `out_valid` out 1: converted beat present.
- `out_ready` in 1: consumer accepts the beat.
- `out_mode` out 1: mode travelling with the beat.
- `out_data` out WIDTH: converted value.

## Operation
- Gray→binary: `b[WIDTH-1] = g[WIDTH-1]`; `b[i] = g[i] ^ b[i+1]`, for i from WIDTH-2 down to 0.
- Binary→Gray: `g = b ^ (b >> 1)`, with a logical shift. It is computed in stage 0, and the result is carried unchanged through the remaining stages.
- Slicing:
  - `SLICE = ceil(WIDTH/STAGES)`.
  - Stage k resolves output bits `[WIDTH-1-k*SLICE : max(0, WIDTH-(k+1)*SLICE)]`, starting from the MSB.
  - If the MSB-first slices finish before the last stage, the remaining stages resolve no bits and only pass the beat through.
  - Each stage registers the partially converted word: resolved bits plus raw input bits not yet converted. The lowest resolved bit serves as the prefix carry for the next stage.
- Each stage holds one valid flag plus its data/mode registers.
  - Stage k loads when `valid_in_k && (!valid_q_k || ready_next_k)`.
  - Stage k clears when its beat leaves and nothing enters.
  - `in_ready = !valid_q_0 || ready_next_0`.
  - The last stage's `ready_next` is `out_ready`.
- Beats are never dropped, duplicated or reordered. Modes may alternate on every beat with no bubble.
- `out_data` and `out_mode` hold stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - All stage valid flags go to 0 immediately.
  - `out_valid = 0`, `out_data = 0`, `out_mode = 0`.
  - `in_ready` reads 1 once every stage's valid flag is 0.
  - Reset mid-stream discards every in-flight beat; after release no stale beat appears.
- Latency: a beat accepted at edge N is presented on `out_*` after edge N+STAGES-1. This is STAGES cycles from `in_valid` to `out_valid`, independent of mode.
- Throughput: one beat per clock when `out_ready` is held high.
- Backpressure:
  - With `out_ready` low, the pipeline absorbs exactly STAGES beats, then `in_ready` drops.
  - `out_ready` going high lets the pipe accept an input beat in the same cycle, so there is no bubble.
- `ready` has a combinational path from `out_ready` to `in_ready` through the stage chain. The stage chain has no data-to-ready combinational path.
- Simultaneous load and unload of a full stage in one cycle is legal and keeps occupancy constant.

## Structure
- Shared package `gray_pkg` contains:
  - `MODE_G2B = 1'b0`, `MODE_B2G = 1'b1`.
  - Function `slice_width(WIDTH, STAGES)`.
  - Functions `gray2bin` and `bin2gray`, reused by the bench as reference models.
- Sub-module `gray_pipe_stage`:
  - Parameters: `WIDTH`, `HI`, `LO` (bit range it resolves).
  - Holds one valid/ready register slice with the prefix-XOR for its bit range.
  - The top level is a generate loop of STAGES instances.

## Test plan
- WIDTH=4, STAGES=1, mode 0, `in_data = 4'b1011` → `out_data = 4'b1101` one cycle later.
- WIDTH=8, STAGES=2:
  - mode 0, `8'hC8` → `8'h8F`.
  - mode 1, `8'h8F` → `8'hC8`.
  - mode 0, `8'hFF` → `8'hAA`.
  - mode 0, `8'h00` → `8'h00`.
  - Each result appears 2 cycles after acceptance.
- WIDTH=8, STAGES=3: exhaustive round trip, feeding all 256 values back to back with alternating modes → every output matches the `gray_pkg` model, one beat per cycle, no bubbles.
- Backpressure, WIDTH=8, STAGES=2:
  - Hold `out_ready = 0` and stream `8'h01`, `8'h02`, `8'h03` → only two beats accepted, then `in_ready = 0`, and `out_data` stays stable.
  - Release → outputs arrive in order.
- Reset mid-stream: with 2 beats in flight, pulse `rst_n` low for a partial cycle → `out_valid` drops immediately, all outputs read 0, and after release no beat appears until new input.
- Random valid/ready toggling for 10k beats at WIDTH=37, STAGES=5 → scoreboard reports zero mismatches, zero losses and zero reorderings.
